// File: rtl/case_bist_ctrl.sv
// BIST sequencer: LFSR stimulus into a fixed-latency decoder and MISR compaction of its
// 1-bit result. The signature is compared against an expected value captured at start.
module case_bist_ctrl #(
    parameter int DEC_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [63:0]      seed,
    input  logic [CNT_W-1:0] num_updates,
    input  logic [63:0]      expect_sig,
    output logic [23:0]      stim,
    output logic             stim_vld,
    input  logic             dec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [63:0]      signature
);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_DRAIN, S_CHECK} state_t;

    state_t           state_q, state_d;
    logic [63:0]      crc_q, crc_d, sum_q, sum_d;
    logic [63:0]      seed_q, seed_d, exp_q, exp_d;
    logic [CNT_W-1:0] num_q, num_d, cnt_q, cnt_d;
    logic             pass_q, pass_d, held_q, held_d;
    logic             dly_vld, pipe_empty, match;

    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [63:0] misr_step(input logic [63:0] v, input logic b);
        return {v[62:0], v[63] ^ v[2] ^ v[0]} ^ {63'h0, b};
    endfunction

    // Valid shadow of the decoder pipeline: the delayed valid marks which dec_out to fold in.
    generate
        if (DEC_LAT == 0) begin : g_comb
            assign dly_vld    = stim_vld;
            assign pipe_empty = 1'b1;
        end else begin : g_pipe
            logic [DEC_LAT-1:0] vp_q;
            always_ff @(posedge clk) begin
                if (!rst_n || abort) begin
                    vp_q <= '0;
                end else begin
                    vp_q[0] <= stim_vld;
                    for (int i = 1; i < DEC_LAT; i++) vp_q[i] <= vp_q[i-1];
                end
            end
            assign dly_vld    = vp_q[DEC_LAT-1];
            assign pipe_empty = (vp_q == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            crc_q   <= '0;
            sum_q   <= '0;
            seed_q  <= '0;
            exp_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            sum_q   <= sum_d;
            seed_q  <= seed_d;
            exp_q   <= exp_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            held_q  <= held_d;
        end
    end

    assign match = (sum_q == exp_q);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        sum_d   = dly_vld ? misr_step(sum_q, dec_out) : sum_q;
        seed_d  = seed_q;
        exp_d   = exp_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        held_d  = held_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seed_d  = seed;
                    num_d   = num_updates;
                    exp_d   = expect_sig;
                    pass_d  = 1'b0;
                    held_d  = 1'b0;
                    sum_d   = '0;
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                crc_d   = seed_q;
                cnt_d   = '0;
                state_d = (num_q == '0) ? S_CHECK : S_RUN;
            end
            S_RUN: begin
                crc_d = lfsr_step(crc_q);
                cnt_d = cnt_q + CNT_W'(1);
                // Compare against N-1 so the all-ones count never needs a wider counter.
                if (cnt_q == num_q - CNT_W'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pipe_empty) state_d = S_CHECK;
            end
            S_CHECK: begin
                pass_d  = match;
                held_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            sum_d   = '0;
            crc_d   = '0;
            cnt_d   = '0;
            pass_d  = 1'b0;
            held_d  = 1'b0;
        end
    end

    assign stim      = crc_q[23:0];
    assign stim_vld  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_CHECK) && !abort;
    assign pass      = (state_q == S_CHECK) ? (match && !abort) : pass_q;
    assign fail      = (state_q == S_CHECK) ? (!match && !abort) : (held_q && !pass_q);
    assign signature = sum_q;

endmodule

// File: doc/case_bist_ctrl.md
# case_bist_ctrl

Built-in self-test sequencer for the nested-casez 24-bit→1-bit decoder. It seeds and steps a 64-bit LFSR stimulus generator and drives the low 24 bits into the decoder each cycle. It folds the decoder's 1-bit result into a 64-bit MISR signature, then compares the signature against an expected value and reports pass or fail. It sits between the test harness (start/abort/result) and one decoder instance whose pipeline latency is fixed at elaboration.

## Interface
- DEC_LAT, 0: decoder latency in cycles from `stim` to `dec_out` (0..3; 0 = combinational)
- CNT_W, 16: width of the update counter
- clk  in  1  sole clock; all state changes on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- start  in  1  single-cycle request to begin a run; honoured only in IDLE
- abort  in  1  return to IDLE next cycle from any state; no result reported
- seed  in  64  LFSR seed, captured on accepted start
- num_updates  in  CNT_W  number of signature updates, captured on accepted start
- expect_sig  in  64  expected signature, captured on accepted start
- stim  out  24  LFSR bits [23:0] to the decoder `in` port
- stim_vld  out  1  `stim` is a live sample that will be accumulated
- dec_out  in  1  decoder result for the `stim` issued DEC_LAT cycles earlier
- busy  out  1  high in SEED, RUN, DRAIN, CHECK
- done  out  1  one-cycle pulse when pass/fail become valid
- pass  out  1  held result, valid from the done pulse until the next accepted start
- fail  out  1  complement of pass while a result is held; 0 otherwise
- signature  out  64  current MISR value

## Operation
- LFSR step: crc' = {crc[62:0], crc[63]^crc[2]^crc[0]}.
- MISR step: sum' = {sum[62:0], sum[63]^sum[2]^sum[0]} ^ {63'h0, bit}.
- States: IDLE → SEED → RUN → DRAIN → CHECK → IDLE.
- IDLE:
  - On start=1, capture seed, num_updates and expect_sig.
  - Clear pass, fail and sum.
  - Go to SEED.
- SEED: crc ← captured seed; issue counter ← 0. If num_updates==0, go straight to CHECK; otherwise go to RUN.
- RUN:
  - stim_vld=1 and stim=crc[23:0] every cycle.
  - crc steps and the issue counter increments each cycle.
  - After the num_updates-th issue, go to DRAIN.
- Accumulation:
  - A DEC_LAT-deep shift register carries stim_vld alongside the decoder pipeline.
  - When the delayed valid is 1, sum ← MISR step with bit = dec_out.
  - Exactly num_updates accumulations happen per run, regardless of DEC_LAT.
- DRAIN:
  - stim_vld=0; crc holds.
  - Stay until the delayed-valid pipe is empty, i.e. DEC_LAT cycles. When DEC_LAT=0, DRAIN lasts one cycle with no accumulation.
- CHECK: pass ← (sum == expect_sig); fail ← !pass; done=1 for this cycle; go to IDLE.
- abort:
  - Has priority over all transitions.
  - Next state is IDLE with sum, crc, counter and the valid pipe cleared.
  - pass=fail=0 and no done pulse.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins; stay in IDLE.
- The counter compares at CNT_W width. num_updates = 2^CNT_W−1 is legal and must not wrap early.

## Timing
- Reset values: state=IDLE; busy=0, done=0, pass=0, fail=0, stim_vld=0, stim=0, signature=0; crc=0; valid pipe cleared.
- Reset mid-run: same as the reset values; nothing from the interrupted run survives.
- Latency:
  - start in cycle t → SEED at t+1.
  - First stim_vld at t+2.
  - Last stim_vld at t+1+N.
  - done at t+3+N+DEC_LAT, where N = num_updates > 0.
- N=0: done at t+2. In that case pass=1 iff expect_sig==0.
- busy is high from t+1 through the done cycle inclusive; low the cycle after.
- The next start is accepted the cycle after done.
- The signature output is registered: it updates the cycle after each accumulation and is stable in CHECK.

## Test plan
- Golden run: DEC_LAT=0, real decoder, seed=64'h97, num_updates=88, expect_sig=64'h2e5cb972eb02b8a0 → done at t+91, pass=1, signature=64'h2e5cb972eb02b8a0.
- Latency independence: same stimulus with DEC_LAT=2 and the decoder output delayed two stages → identical signature, pass=1, done at t+93.
- Mismatch: golden run with expect_sig=0 → done pulse, pass=0, fail=1; a subsequent start clears both the cycle after it is accepted.
- Zero length: num_updates=0, expect_sig=0 → no stim_vld, done at t+2, pass=1.
- Abort:
  - Abort at RUN issue 40 → IDLE next cycle, busy=0, signature=0, no done.
  - A new golden start then passes.
  - A start issued while busy is ignored; the run count stays 88.
- Reset mid-DRAIN: rst_n=0 for one cycle with DEC_LAT=3 → all outputs at reset values next cycle; no accumulation from in-flight samples after release.
